// File: rtl/swt16_pkg.sv
// swt16_pkg: fetch-state encoding and default sizes shared across the SWT16 fetch path.
// FLUSH_CYCLES default matches the decoder pipeline depth.
package swt16_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_FLUSH = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

  localparam int SWT16_PC_WIDTH        = 12;
  localparam int SWT16_IALU_WORD_WIDTH = 16;
  localparam int SWT16_FLUSH_CYCLES    = 2;
  localparam int SWT16_FLUSH_CNT_WIDTH = 3;

  // Clamp to the counter's legal range 1..7 so a bad override can never load 0.
  function automatic logic [SWT16_FLUSH_CNT_WIDTH-1:0] flush_load_value(input int cycles);
    if (cycles < 1) begin
      return 3'd1;
    end else if (cycles > 7) begin
      return 3'd7;
    end else begin
      return SWT16_FLUSH_CNT_WIDTH'(cycles);
    end
  endfunction

endpackage

// File: rtl/fetch_sequencer_flush_timer.sv
// flush_timer: loadable down-counter for the post-jump flush window.
// busy while nonzero, last on the final count; hold freezes the count.
module flush_timer
  import swt16_pkg::*;
#(
  parameter int CNT_WIDTH = SWT16_FLUSH_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 hold,
  output logic                 busy,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] count_r;

  // Count register: load wins, then decrement while not held and not yet empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (!hold && (count_r != '0)) begin
      count_r <= count_r - CNT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign busy = (count_r != '0);
  assign last = (count_r == CNT_WIDTH'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: SWT16 program counter, fetch enable and decoder flush sequencing.
// Optional range trap (HALT state) enabled by defining SWT16_PC_RANGE_CHECK_EN.
module fetch_sequencer
  import swt16_pkg::*;
#(
  parameter int PC_WIDTH        = SWT16_PC_WIDTH,
  parameter int IALU_WORD_WIDTH = SWT16_IALU_WORD_WIDTH,
  parameter int FLUSH_CYCLES    = SWT16_FLUSH_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_stall,
  input  logic                       in_jump,
  input  logic [IALU_WORD_WIDTH-1:0] in_jump_target,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_pmem_rd_en,
  output logic                       out_flush,
  output logic                       out_trap
);

  localparam logic [1:0] ST_BOOT  = FS_BOOT;
  localparam logic [1:0] ST_FETCH = FS_FETCH;
  localparam logic [1:0] ST_FLUSH = FS_FLUSH;
  localparam logic [1:0] ST_HALT  = FS_HALT;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic [PC_WIDTH-1:0] pc_next_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] target_pc_s;
  logic                target_hi_err_s;
  logic                pc_at_max_s;
  logic                timer_load_s;
  logic                timer_hold_s;
  logic                timer_busy_s;
  logic                timer_last_s;

  assign pc_inc_s    = out_pc + PC_WIDTH'(1);
  assign target_pc_s = in_jump_target[PC_WIDTH-1:0];

`ifdef SWT16_PC_RANGE_CHECK_EN
  assign target_hi_err_s = |in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH];
  assign pc_at_max_s     = &out_pc;
`else
  logic unused_target_hi_s;
  assign unused_target_hi_s = ^in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH];
  assign target_hi_err_s    = 1'b0;
  assign pc_at_max_s        = 1'b0;
`endif

  flush_timer #(
    .CNT_WIDTH (SWT16_FLUSH_CNT_WIDTH)
  ) u_flush_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load_s),
    .load_value (flush_load_value(FLUSH_CYCLES)),
    .hold       (timer_hold_s),
    .busy       (timer_busy_s),
    .last       (timer_last_s)
  );

  // Next-state / next-PC selection; a trap condition freezes the PC at its current value.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = out_pc;
    timer_load_s = 1'b0;
    timer_hold_s = 1'b1;
    case (state_r)
      ST_BOOT: begin
        state_next_s = ST_FETCH;
        pc_next_s    = '0;
      end
      ST_FETCH: begin
        if (in_jump) begin
          if (target_hi_err_s) begin
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_FLUSH;
            pc_next_s    = target_pc_s;
            timer_load_s = 1'b1;
          end
        end else if (in_stall) begin
          state_next_s = ST_FETCH;
        end else if (pc_at_max_s) begin
          state_next_s = ST_HALT;
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
      ST_FLUSH: begin
        // Jumps here come from squashed wrong-path instructions and are dropped.
        if (in_stall) begin
          state_next_s = ST_FLUSH;
        end else if (pc_at_max_s) begin
          state_next_s = ST_HALT;
        end else begin
          timer_hold_s = 1'b0;
          pc_next_s    = pc_inc_s;
          if (timer_last_s || !timer_busy_s) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_BOOT;
        pc_next_s    = '0;
      end
    endcase
  end

  // State, PC and fetch/flush outputs registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_BOOT;
      out_pc         <= '0;
      out_pmem_rd_en <= 1'b0;
      out_flush      <= 1'b1;
    end else begin
      state_r        <= state_next_s;
      out_pc         <= pc_next_s;
      out_pmem_rd_en <= (state_next_s == ST_FETCH) || (state_next_s == ST_FLUSH);
      out_flush      <= (state_next_s != ST_FETCH);
    end
  end

`ifdef SWT16_PC_RANGE_CHECK_EN
  // Sticky trap: HALT is only left through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_trap <= 1'b0;
    end else begin
      out_trap <= (state_next_s == ST_HALT);
    end
  end
`else
  assign out_trap = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Owns the program counter and sequences instruction fetch for the SWT16 core.
- Drives the program-memory address, read enable and decoder flush.
- Accepts jump requests from the execute stage and squashes the wrong-path instructions already in flight.
- Sits between program memory, the decoder (`in_flush`, `in_pc`) and the IALU jump result.

## Interface
Parameters:
- PC_WIDTH, 12, width of PC and program-memory word address
- IALU_WORD_WIDTH, 16, width of jump target from IALU
- FLUSH_CYCLES, 2, cycles of `out_flush` after a taken jump; legal range 1..7

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_stall  input  1  freeze fetch; PC and flush counter hold
- in_jump  input  1  taken jump from execute, valid for one cycle
- in_jump_target  input  IALU_WORD_WIDTH  IALU result; new PC
- out_pc  output  PC_WIDTH  registered fetch address; also feeds decoder `in_pc`
- out_pmem_rd_en  output  1  program-memory read enable
- out_flush  output  1  decoder flush
- out_trap  output  1  sticky range-violation flag; 0 when feature compiled out

## Operation
- States: BOOT, FETCH, FLUSH, HALT.
- **Reset values:**
  - state = BOOT
  - out_pc = 0
  - out_pmem_rd_en = 0
  - out_flush = 1
  - out_trap = 0
  - flush counter = 0
- **BOOT:**
  - Lasts one cycle.
  - out_flush = 1 and out_pmem_rd_en = 0.
  - Next state is FETCH with out_pc = 0.
  - in_jump and in_stall are ignored.
- **FETCH:**
  - out_pmem_rd_en = 1 and out_flush = 0.
  - Each non-stalled cycle: out_pc <= out_pc + 1, mod 2^PC_WIDTH.
- **Jump** (sampled in FETCH; has priority over in_stall):
  - out_pc <= in_jump_target[PC_WIDTH-1:0].
  - Counter <= FLUSH_CYCLES.
  - State <= FLUSH.
- **FLUSH:**
  - out_flush = 1 and out_pmem_rd_en = 1.
  - Fetch continues from the target: PC increments as in FETCH.
  - Counter decrements each non-stalled cycle; at counter == 1 the next state is FETCH.
  - in_jump is ignored, because it originates from squashed instructions.
  - in_stall holds the PC and the counter; out_flush stays 1.
- **HALT:**
  - Entered only with the range-check feature; see Configuration.
  - out_pmem_rd_en = 0, out_flush = 1, out_trap = 1, PC frozen.
  - Exit only via reset.
- **Arithmetic:**
  - PC increment is unsigned PC_WIDTH.
  - Target upper bits [IALU_WORD_WIDTH-1:PC_WIDTH] are discarded unless range checking is enabled.
  - Counter width is 3 bits.
- **Reset mid-operation:** asynchronous return to BOOT values, from any state including FLUSH with a partial count.

## Timing
- out_pc, out_flush, out_pmem_rd_en and out_trap are all registered; no combinational input-to-output path.
- in_jump sampled high at edge k:
  - out_pc = target from cycle k+1.
  - out_flush is high for cycles k+1 .. k+FLUSH_CYCLES (non-stalled cycles).
  - out_flush is low from k+FLUSH_CYCLES+1.
- Stall sampled at edge k: out_pc at k+1 equals out_pc at k.
- Stall released: the increment resumes on the same edge.
- Jump and stall in the same cycle: the jump wins; the stall is dropped for that cycle.
- Back-to-back jumps: the second is ignored if it arrives while in FLUSH.
- A jump in the first FETCH cycle after FLUSH is accepted.

## Configuration
Macro `SWT16_PC_RANGE_CHECK_EN`.

Defined:
- Any nonzero bit in in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH] on an accepted jump enters HALT at the next edge.
- An increment from out_pc = 2^PC_WIDTH-1 enters HALT at the next edge.
- In both cases out_trap is set and out_pc holds its last value: the pre-jump PC, or all-ones.

Undefined:
- Target bits are truncated and the PC wraps to 0.
- HALT is unreachable and out_trap is tied to 0.

## Structure
- Shared package `swt16_pkg`:
  - fetch state enum (BOOT, FETCH, FLUSH, HALT)
  - default PC_WIDTH and IALU_WORD_WIDTH constants
  - FLUSH_CYCLES default constant, shared with the decoder pipeline depth
- One sub-module, `flush_timer`:
  - Loadable down-counter with hold (stall) input.
  - Outputs `busy` and `last`.
- PC register, next-PC mux and state machine live in the top module.

## Test plan
- **Reset then run, no stall:**
  - out_flush = 1 for the BOOT cycle.
  - out_pc then 0,1,2,3… with out_pmem_rd_en = 1.
- **Jump to 0x0A5 from out_pc = 0x010, FLUSH_CYCLES = 2:**
  - Next cycle out_pc = 0x0A5.
  - out_flush high for exactly 2 cycles (0x0A5, 0x0A6).
  - out_flush low at 0x0A7.
- **in_stall held 3 cycles at out_pc = 0x005:**
  - out_pc stays 0x005 for 3 cycles, then 0x006.
- **Stall during FLUSH:**
  - out_flush stays high for 2 non-stalled cycles plus the stalled cycles.
  - in_jump during FLUSH is ignored.
- **Simultaneous in_jump (target 0x200) and in_stall:**
  - out_pc = 0x200 next cycle.
- **Range violations:**
  - Wrap from 0xFFF: out_pc = 0x000 without the macro; with the macro, HALT, out_trap = 1, out_pmem_rd_en = 0.
  - Jump to 0x1234: out_pc = 0x234 without the macro; with the macro, HALT, out_trap = 1.
  - With the macro, a reset asserted while in HALT returns to BOOT values.
